// File: rtl/timer_loader_pkg.sv
// Shared definitions for the timer entry/control stage.
//   - FSM state encodings (3 bits)
//   - BCD digit width, largest legal seconds-tens digit, keypad width
//   - digits_t: the three loaded digits (mm:ss as m:ts)
//   - key_code(): one-hot keypad vector -> digit index
package timer_loader_pkg;

  localparam int BCD_W    = 4;
  localparam int MAX_TENS = 5;
  localparam int NUM_KEYS = 10;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef struct packed {
    logic [BCD_W-1:0] mins;
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
  } digits_t;

  // Index of the set bit; only meaningful for one-hot input.
  function automatic logic [BCD_W-1:0] key_code(input logic [NUM_KEYS-1:0] k);
    key_code = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (k[i]) key_code = BCD_W'(i);
  endfunction

endpackage

// File: rtl/timer_loader_key_debounce.sv
// key_debounce: stable-count debouncer with rising-edge event.
//   clk, clearn : clock, async active-low reset
//   din   [W]   : raw level(s)
//   level [W]   : accepted level, updated once din has been identical for
//                 DEB_CYCLES consecutive clock edges
//   rise        : 1-cycle pulse, coincident with level leaving all-zero
// The vector form (W>1) debounces the whole vector as one value, so any bit
// changing restarts the count.
module key_debounce #(
  parameter int W          = 1,
  parameter int DEB_CYCLES = 2
) (
  input  logic         clk,
  input  logic         clearn,
  input  logic [W-1:0] din,
  output logic [W-1:0] level,
  output logic         rise
);

  localparam int              CW  = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0]   DEB = CW'(DEB_CYCLES);

  logic [W-1:0]  smp;
  logic [CW-1:0] cnt;
  logic [CW-1:0] run;

  // run = number of consecutive edges (including this one) sampling din;
  // saturates at DEB so it never wraps while a key is held.
  always_comb begin
    run = CW'(1);
    if (din == smp) run = (cnt == DEB) ? cnt : cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      smp   <= '0;
      cnt   <= '0;
      level <= '0;
      rise  <= 1'b0;
    end else begin
      smp  <= din;
      cnt  <= run;
      rise <= 1'b0;
      if (run == DEB && din != level) begin
        level <= din;
        rise  <= (level == '0);
      end
    end
  end

endmodule

// File: rtl/timer_loader.sv
// timer_loader: keypad entry + control FSM ahead of the mm:ss BCD counters.
//   clk, clearn          : clock, async active-low reset
//   keypad[10]           : raw key levels, bit k = digit k
//   start, stop          : raw control key levels
//   cnt_zero             : downstream counters all read zero
//   data_mins/tens/ones  : BCD digits presented to the counters' load inputs
//   loadn                : active-low parallel load, low for the LOAD cycle
//   en                   : count enable, high exactly while in RUN
//   err                  : 1-cycle pulse, start refused (000 or tens > 5)
//   done                 : 1-cycle pulse, countdown finished
module timer_loader
  import timer_loader_pkg::*;
#(
  parameter int DEB_CYCLES = 2
) (
  input  logic               clk,
  input  logic               clearn,
  input  logic [NUM_KEYS-1:0] keypad,
  input  logic               start,
  input  logic               stop,
  input  logic               cnt_zero,
  output logic [BCD_W-1:0]   data_mins,
  output logic [BCD_W-1:0]   data_tens,
  output logic [BCD_W-1:0]   data_ones,
  output logic               loadn,
  output logic               en,
  output logic               err,
  output logic               done
);

  logic [NUM_KEYS-1:0] key_lvl;
  logic                key_rise;
  logic [1:0]          ctl_raw, ctl_lvl, ctl_rise;

  key_debounce #(.W(NUM_KEYS), .DEB_CYCLES(DEB_CYCLES)) u_key (
    .clk   (clk),
    .clearn(clearn),
    .din   (keypad),
    .level (key_lvl),
    .rise  (key_rise)
  );

  assign ctl_raw = {stop, start};

  for (genvar g = 0; g < 2; g++) begin : g_ctl
    key_debounce #(.W(1), .DEB_CYCLES(DEB_CYCLES)) u_db (
      .clk   (clk),
      .clearn(clearn),
      .din   (ctl_raw[g]),
      .level (ctl_lvl[g]),
      .rise  (ctl_rise[g])
    );
  end

  logic    start_ev, stop_ev, key_ev, dig_ok;
  logic [2:0] state;
  digits_t dig;

  // rise already implies the new level is high; the AND keeps the
  // accepted level as the qualifying term.
  assign start_ev = ctl_rise[0] & ctl_lvl[0];
  assign stop_ev  = ctl_rise[1] & ctl_lvl[1];
  // Leaving zero into a multi-key chord produces a rise but no key event.
  assign key_ev   = key_rise & $onehot(key_lvl);
  assign dig_ok   = (dig != '0) && (dig.tens <= BCD_W'(MAX_TENS));

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state <= ST_IDLE;
      dig   <= '0;
      loadn <= 1'b1;
      en    <= 1'b0;
      err   <= 1'b0;
      done  <= 1'b0;
    end else begin
      loadn <= 1'b1;
      err   <= 1'b0;
      done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (stop_ev) begin
            dig <= '0;
          end else if (start_ev) begin
            if (dig_ok) begin
              state <= ST_LOAD;
              loadn <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end else if (key_ev) begin
            dig <= '{mins: dig.tens, tens: dig.ones, ones: key_code(key_lvl)};
          end
        end
        ST_LOAD: begin
          state <= ST_RUN;
          en    <= 1'b1;
        end
        ST_RUN: begin
          if (cnt_zero) begin
            state <= ST_DONE;
            en    <= 1'b0;
            done  <= 1'b1;
          end else if (stop_ev) begin
            state <= ST_PAUSE;
            en    <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (stop_ev) begin
            state <= ST_IDLE;
            dig   <= '0;
          end else if (start_ev) begin
            state <= ST_RUN;
            en    <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          dig   <= '0;
        end
        default: begin
          state <= ST_IDLE;
          dig   <= '0;
          en    <= 1'b0;
        end
      endcase
    end
  end

  assign data_mins = dig.mins;
  assign data_tens = dig.tens;
  assign data_ones = dig.ones;

endmodule
